// File: rtl/countdown_alarm.sv
// Debounced k-of-n hazard vote driving a shrinking, blinking LED bar.
// Arm switch aborts at any time and restores the full bar.
module countdown_alarm #(
  parameter int N_IN        = 3,
  parameter int VOTE_K      = 2,
  parameter int TICK_DIV    = 120000,
  parameter int DEB_TICKS   = 3,
  parameter int STEP_TICKS  = 100,
  parameter int BLINK_TICKS = 33,
  parameter int LED_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [N_IN-1:0]  sw,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       state,
  output logic             done
);

  localparam int NCH  = N_IN + 1;
  localparam int DIVW = $clog2(TICK_DIV);
  localparam int DEBW = $clog2(DEB_TICKS + 1);
  localparam int STW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int BLW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int PCW  = $clog2(N_IN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } st_t;

  st_t              st;
  logic [DIVW-1:0]  div;
  logic             tick;
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   deb;
  logic [DEBW-1:0]  dcnt [NCH];
  logic             arm_d;
  logic [N_IN-1:0]  sw_d;
  logic [PCW-1:0]   pop;
  logic             vote;
  logic [LED_W-1:0] bar;
  logic [STW-1:0]   step;
  logic [BLW-1:0]   blink;
  logic             phase;
  logic             step_end;
  logic             blink_end;
  logic             shift;
  logic [LED_W-1:0] bar_sh;
  logic [LED_W-1:0] bar_nx;
  logic             ph_nx;

  assign state = st;
  assign raw   = {arm, sw};
  assign arm_d = deb[N_IN];
  assign sw_d  = deb[N_IN-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIVW'(TICK_DIV - 1));
      if (div == DIVW'(TICK_DIV - 1)) div <= '0;
      else div <= div + DIVW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < NCH; i++) dcnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (raw[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEBW'(DEB_TICKS - 1)) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DEBW'(1);
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_IN; i++) pop = pop + PCW'(sw_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vote <= 1'b0;
    else vote <= (pop >= PCW'(VOTE_K));
  end

  // Values the bar and blink phase take if COUNT keeps running this cycle
  always_comb begin
    step_end  = (step == STW'(STEP_TICKS - 1));
    blink_end = (blink == BLW'(BLINK_TICKS - 1));
    shift     = tick && step_end;
    bar_sh    = bar >> 1;
    bar_nx    = shift ? bar_sh : bar;
    ph_nx     = (tick && blink_end) ? ~phase : phase;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      bar   <= '1;
      leds  <= '1;
      done  <= 1'b0;
      step  <= '0;
      blink <= '0;
      phase <= 1'b1;
    end else if (!arm_d) begin
      st    <= IDLE;
      bar   <= '1;
      leds  <= '1;
      done  <= 1'b0;
      step  <= '0;
      blink <= '0;
      phase <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          bar   <= '1;
          leds  <= '1;
          done  <= 1'b0;
          step  <= '0;
          blink <= '0;
          phase <= 1'b1;
          if (vote) st <= COUNT;
        end
        COUNT: begin
          if (tick) begin
            step  <= step_end ? '0 : step + STW'(1);
            blink <= blink_end ? '0 : blink + BLW'(1);
            phase <= ph_nx;
          end
          if (shift && bar_sh == '0) begin
            st   <= DONE;
            bar  <= '0;
            leds <= '0;
            done <= 1'b1;
          end else begin
            bar <= bar_nx;
            if (!vote) begin
              st   <= HOLD;
              leds <= bar_nx;
            end else begin
              leds <= ph_nx ? bar_nx : '0;
            end
          end
        end
        HOLD: begin
          leds <= bar;
          if (vote) begin
            st    <= COUNT;
            phase <= 1'b1;
          end
        end
        DONE: begin
          bar  <= '0;
          leds <= '0;
          done <= 1'b1;
        end
      endcase
    end
  end

endmodule
